// File: rtl/btn_tx_sequencer.sv
// Debug helper: buffers UART RX words and releases them to UART TX on a debounced
// button press, optionally transforming each word (echo / increment / invert / drain).
module btn_tx_sequencer #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned INC_VAL         = 1,
  parameter int unsigned BUSY_TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn,
  input  logic [1:0]                    mode,
  input  logic [DATA_W-1:0]             rx_data,
  input  logic                          rx_done,
  input  logic                          tx_busy,
  output logic [DATA_W-1:0]             tx_data,
  output logic                          tx_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  localparam logic [1:0] MODE_INC   = 2'd1;
  localparam logic [1:0] MODE_INV   = 2'd2;
  localparam logic [1:0] MODE_DRAIN = 2'd3;

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              db_q, db_d, press_q, press_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [1:0]        state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;

  logic              full, empty, pop, push_ok;
  logic [DATA_W-1:0] head, xform;

  // Synchroniser, debounce and rising-edge detection of the button
  always_comb begin
    sync1_d  = btn;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = rx_done && (!full || pop);
  assign head    = mem_q[rd_ptr_q];

  // Transform applied to the word leaving the FIFO
  always_comb begin
    case (mode)
      MODE_INC: xform = head + DATA_W'(INC_VAL);
      MODE_INV: xform = ~head;
      default:  xform = head;
    endcase
  end

  // Receive FIFO; a push while full survives only if a pop frees a slot the same cycle
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (rx_done && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Send sequencer: trigger -> start pulse -> wait for busy rise -> wait for busy fall
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pending_d  = pending_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_q || pending_q) begin
          pending_d = 1'b0;
          if (!empty) begin
            pop        = 1'b1;
            tx_data_d  = xform;
            tx_start_d = 1'b1;
            tmo_d      = '0;
            state_d    = S_WAIT_BUSY;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (press_q) begin
          pending_d = 1'b1;
        end
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (press_q) begin
          pending_d = 1'b1;
        end
        if (!tx_busy) begin
          if (mode == MODE_DRAIN && !empty) begin
            pop        = 1'b1;
            tx_data_d  = xform;
            tx_start_d = 1'b1;
            tmo_d      = '0;
            state_d    = S_WAIT_BUSY;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      pending_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      pending_q  <= pending_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
